// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath/register widths, common types and the
// operand-stage occupancy states.
package cpu_defs;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/operand_bypass.sv
// Per-source operand select: r0 reads zero, otherwise the youngest in-flight
// writer (EX, then MEM, then WB write-through) wins over the regfile value.
module operand_bypass
    import cpu_defs::*;
#(
    parameter int unsigned XLEN = cpu_defs::XLEN,
    parameter int unsigned AW   = cpu_defs::AW
) (
    input  logic [AW-1:0]   rs,
    input  logic            use_rs,
    input  logic [XLEN-1:0] rdata,
    input  logic            ex_we,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ex_is_load,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic [XLEN-1:0] operand
);

    logic is_zero;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        is_zero = (rs == AW'(REG_ZERO));
        // A load in EX has no data yet; the hazard stall keeps it from being used.
        ex_hit  = ex_we && (ex_rd == rs) && !ex_is_load;
        mem_hit = mem_we && (mem_rd == rs);
        wb_hit  = wb_we && (wb_waddr == rs);
    end

    always_comb begin
        operand = '0;
        if (use_rs && !is_zero) begin
            if (ex_hit)
                operand = ex_data;
            else if (mem_hit)
                operand = mem_data;
            else if (wb_hit)
                operand = wb_wdata;
            else
                operand = rdata;
        end
    end

endmodule

// File: rtl/reg_read_stage.sv
// Decode-to-execute operand stage: regfile read ports, EX/MEM/WB bypass,
// load-use hazard detection and a valid/ready ID/EX pipeline register.
module reg_read_stage
    import cpu_defs::*;
#(
    parameter int unsigned XLEN  = cpu_defs::XLEN,
    parameter int unsigned AW    = cpu_defs::AW,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rs1,
    input  logic             in_use_rs1,
    input  logic [AW-1:0]    in_rs2,
    input  logic             in_use_rs2,
    input  logic [AW-1:0]    in_rd,
    input  logic             in_rd_we,
    input  logic             in_is_load,
    input  logic [TAG_W-1:0] in_tag,
    output logic             re1,
    output logic [AW-1:0]    raddr1,
    input  logic [XLEN-1:0]  rdata1,
    output logic             re2,
    output logic [AW-1:0]    raddr2,
    input  logic [XLEN-1:0]  rdata2,
    input  logic             ex_we,
    input  logic [AW-1:0]    ex_rd,
    input  logic [XLEN-1:0]  ex_data,
    input  logic             ex_is_load,
    input  logic             mem_we,
    input  logic [AW-1:0]    mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_waddr,
    input  logic [XLEN-1:0]  wb_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [AW-1:0]    out_rd,
    output logic             out_rd_we,
    output logic             out_is_load,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      stall_cnt
);

    stage_state_t    state_q;
    stage_state_t    state_d;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hazard;
    logic            accept;
    logic            capture;

    always_comb begin
        re1    = in_valid && in_use_rs1 && (in_rs1 != AW'(REG_ZERO));
        re2    = in_valid && in_use_rs2 && (in_rs2 != AW'(REG_ZERO));
        raddr1 = in_rs1;
        raddr2 = in_rs2;
    end

    operand_bypass #(.XLEN(XLEN), .AW(AW)) u_bypass1 (
        .rs(in_rs1), .use_rs(in_use_rs1), .rdata(rdata1),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .operand(op1)
    );

    operand_bypass #(.XLEN(XLEN), .AW(AW)) u_bypass2 (
        .rs(in_rs2), .use_rs(in_use_rs2), .rdata(rdata2),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .operand(op2)
    );

    always_comb begin
        hazard = in_valid && ex_we && ex_is_load && (ex_rd != AW'(REG_ZERO)) &&
                 ((in_use_rs1 && (in_rs1 == ex_rd)) || (in_use_rs2 && (in_rs2 == ex_rd)));
        in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    // A hazard while FULL and draining falls through to EMPTY: that is the bubble.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL:  if (out_ready) state_d = accept ? ST_FULL : ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        capture   = accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_is_load <= 1'b0;
            out_tag     <= '0;
        end else if (capture) begin
            out_op1     <= op1;
            out_op2     <= op2;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
            out_is_load <= in_is_load;
            out_tag     <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: stimulus pushes expected ID/EX contents,
// a negedge monitor pops and compares whenever EX consumes the register.
module tb_reg_read_stage;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
    logic [31:0] in_tag;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_we, ex_is_load, mem_we, wb_we;
    logic [4:0]  ex_rd, mem_rd, wb_waddr;
    logic [31:0] ex_data, mem_data, wb_wdata;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2, out_tag, stall_cnt;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_is_load;

    logic [31:0] regs [32];
    exp_t        exp_q[$];
    exp_t        dropped;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

    reg_read_stage #(.XLEN(32), .AW(5), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_use_rs1(in_use_rs1), .in_rs2(in_rs2), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_tag(in_tag),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_tag(out_tag),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we,
                         input logic ld, input logic [31:0] tag);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_use_rs1 = u1;
        in_rs2     = rs2;
        in_use_rs2 = u2;
        in_rd      = rd;
        in_rd_we   = we;
        in_is_load = ld;
        in_tag     = tag;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic clear_fwd();
        ex_we = 1'b0; ex_rd = '0; ex_data = '0; ex_is_load = 1'b0;
        mem_we = 1'b0; mem_rd = '0; mem_data = '0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    endtask

    task automatic expect_out(input logic [31:0] o1, input logic [31:0] o2, input logic [4:0] rd,
                              input logic we, input logic ld, input logic [31:0] tag);
        exp_t e;
        e.op1 = o1; e.op2 = o2; e.rd = rd; e.rd_we = we; e.is_load = ld; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: the register is consumed at the next posedge when valid & ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: tag 0x%0h with no expected entry", out_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_op1", out_op1, e.op1);
                chk("out_op2", out_op2, e.op2);
                chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, e.rd_we});
                chk("out_is_load", {31'd0, out_is_load}, {31'd0, e.is_load});
                chk("out_tag", out_tag, e.tag);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
        regs[19] = 32'd123456;
        regs[23] = 32'd654321;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        clear_fwd();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 32'hDEAD);

        // Reset: presented instruction neither accepted nor counted
        next_cycle();
        #1 chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
        next_cycle();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_op1", out_op1, 32'd0);
        chk("rst_out_tag", out_tag, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);

        // Plain regfile read
        next_cycle();
        issue(5'd19, 1'b1, 5'd23, 1'b1, 5'd3, 1'b1, 1'b0, 32'hA1);
        #1;
        chk("re1_read", {31'd0, re1}, 32'd1);
        chk("re2_read", {31'd0, re2}, 32'd1);
        chk("raddr1", {27'd0, raddr1}, 32'd19);
        chk("in_ready_empty", {31'd0, in_ready}, 32'd1);
        expect_out(32'd123456, 32'd654321, 5'd3, 1'b1, 1'b0, 32'hA1);

        // r0 source ignores a matching EX writer
        next_cycle();
        issue(5'd0, 1'b1, 5'd5, 1'b0, 5'd4, 1'b0, 1'b0, 32'hA2);
        ex_we = 1'b1; ex_rd = 5'd0; ex_data = 32'd5;
        #1;
        chk("re1_r0", {31'd0, re1}, 32'd0);
        chk("re2_unused", {31'd0, re2}, 32'd0);
        expect_out(32'd0, 32'd0, 5'd4, 1'b0, 1'b0, 32'hA2);

        // Bypass priority EX > MEM > WB, back-to-back accepts
        next_cycle();
        issue(5'd19, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 32'hA3);
        ex_we = 1'b1; ex_rd = 5'd19; ex_data = 32'd1;
        mem_we = 1'b1; mem_rd = 5'd19; mem_data = 32'd2;
        wb_we = 1'b1; wb_waddr = 5'd19; wb_wdata = 32'd233;
        expect_out(32'd1, 32'd0, 5'd5, 1'b1, 1'b0, 32'hA3);
        next_cycle();
        in_tag = 32'hA4; ex_we = 1'b0;
        expect_out(32'd2, 32'd0, 5'd5, 1'b1, 1'b0, 32'hA4);
        next_cycle();
        in_tag = 32'hA5; mem_we = 1'b0;
        #1 chk("in_ready_b2b", {31'd0, in_ready}, 32'd1);
        expect_out(32'd233, 32'd0, 5'd5, 1'b1, 1'b0, 32'hA5);

        // Load-use hazard: bubble, then accept with MEM forwarding
        next_cycle();
        clear_fwd();
        issue(5'd23, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 32'hB0);
        expect_out(32'd654321, 32'd0, 5'd7, 1'b1, 1'b1, 32'hB0);
        next_cycle();
        issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 32'hB1);
        ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; ex_data = 32'd555;
        #1 chk("in_ready_hazard", {31'd0, in_ready}, 32'd0);
        next_cycle();
        clear_fwd();
        mem_we = 1'b1; mem_rd = 5'd7; mem_data = 32'd99;
        #1;
        chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_hazard", {31'd0, in_ready}, 32'd1);
        chk("stall_cnt_hazard", stall_cnt, 32'd1);
        expect_out(32'd0, 32'd99, 5'd8, 1'b1, 1'b0, 32'hB1);

        // Backpressure: hold three cycles, then back-to-back replacement
        next_cycle();
        clear_fwd();
        issue(5'd19, 1'b1, 5'd23, 1'b1, 5'd9, 1'b1, 1'b0, 32'hC0);
        expect_out(32'd123456, 32'd654321, 5'd9, 1'b1, 1'b0, 32'hC0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            out_ready = 1'b0;
            issue(5'd23, 1'b1, 5'd19, 1'b1, 5'd10, 1'b0, 1'b0, 32'hC1);
            #1;
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_out_op1", out_op1, 32'd123456);
            chk("hold_out_tag", out_tag, 32'hC0);
        end
        next_cycle();
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("stall_cnt_hold", stall_cnt, 32'd4);
        expect_out(32'd654321, 32'd123456, 5'd10, 1'b0, 1'b0, 32'hC1);
        next_cycle();
        idle();
        #1 chk("no_bubble_out_valid", {31'd0, out_valid}, 32'd1);

        // Flush while FULL with an incoming instruction
        next_cycle();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 32'hD0);
        expect_out(32'h1001, 32'h1002, 5'd11, 1'b1, 1'b0, 32'hD0);
        next_cycle();
        out_ready = 1'b0; flush = 1'b1;
        issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0, 32'hD1);
        #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        next_cycle();
        flush = 1'b0;
        idle();
        #1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_stall_cnt", stall_cnt, 32'd4);
        dropped = exp_q.pop_front();

        // Reset while FULL
        next_cycle();
        out_ready = 1'b1;
        issue(5'd5, 1'b1, 5'd6, 1'b1, 5'd13, 1'b1, 1'b1, 32'hE0);
        expect_out(32'h1005, 32'h1006, 5'd13, 1'b1, 1'b1, 32'hE0);
        next_cycle();
        out_ready = 1'b0; rst = 1'b1;
        idle();
        #1 chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_op1", out_op1, 32'd0);
        chk("midrst_out_op2", out_op2, 32'd0);
        chk("midrst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("midrst_out_is_load", {31'd0, out_is_load}, 32'd0);
        chk("midrst_out_tag", out_tag, 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        dropped = exp_q.pop_front();

        next_cycle();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
